// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive deserializer.
//   - rx_state_e : receive FSM states
//   - OVS        : oversample ticks per bit
//   - DO_*       : bit positions inside the packed word sent to the RX FIFO
//   - pack_word  : builds the 12-bit status+data word
package uart_pkg;

  localparam int OVS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int DO_DATA_LSB = 0;
  localparam int DO_PERR     = 8;
  localparam int DO_FERR     = 9;
  localparam int DO_BRK      = 10;
  localparam int DO_OVR      = 11;
  localparam int DO_W        = 12;

  function automatic logic [DO_W-1:0] pack_word(input logic [7:0] data,
                                                input logic       perr,
                                                input logic       ferr,
                                                input logic       brk,
                                                input logic       ovr);
    logic [DO_W-1:0] w;
    w = '0;
    w[DO_DATA_LSB +: 8] = data;
    w[DO_PERR]          = perr;
    w[DO_FERR]          = ferr;
    w[DO_BRK]           = brk;
    w[DO_OVR]           = ovr;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
//   clk, rst_n : clock / async active-low reset
//   tick       : one-clk pulse every OVS_DIV clks
module uart_baud_tick #(
  parameter int OVS_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x-oversampling UART receiver that writes one packed
// status+data word per frame into a downstream FIFO.
//   clk, rst_n  : clock / async active-low reset
//   rx          : asynchronous serial line, idle high
//   parity_odd  : parity sense (1 = odd), only used with UART_RX_PARITY_EN
//   full        : downstream FIFO full
//   wr_en       : one-cycle FIFO write strobe
//   data_out    : [7:0] data, [8] parity err, [9] framing err, [10] break,
//                 [11] overrun (words dropped since last write)
//   busy        : FSM not in IDLE
// Build option: define UART_RX_PARITY_EN for 8x1 frames with a parity bit;
// otherwise frames are 8N1 and data_out[8] is always 0.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  parity_odd,
  input  logic                  full,
  output logic                  wr_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  busy
);

  logic tick;

  uart_baud_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer; resets to the idle level so no false start.
  logic rx_m_q, rx_s_q;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  assign rx_s = rx_s_q;

  rx_state_e             state_q, state_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  ovr_q, ovr_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  perr;
  logic                  mid_hit, bit_hit;
  logic                  ferr;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign perr = 1'b0;
`endif

  // START samples at half a bit; every later sample is a full bit on.
  assign mid_hit = tick && (tcnt_q == 4'(OVS/2 - 1));
  assign bit_hit = tick && (tcnt_q == 4'(OVS - 1));
  assign ferr    = !rx_s;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    ovr_d      = ovr_q;
    wr_en_d    = 1'b0;
    data_out_d = data_out_q;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif
    if (tick) tcnt_d = tcnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (mid_hit) begin
          tcnt_d = '0;
          bcnt_d = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
          perr_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          shift_d = {rx_s, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_hit) begin
          perr_d  = ((^shift_q) ^ rx_s) != parity_odd;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_hit) begin
          if (full) begin
            ovr_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            data_out_d = FIFO_WIDTH'(pack_word(shift_q, perr, ferr,
                                               ferr && (shift_q == 8'h00), ovr_q));
            ovr_d      = 1'b0;
          end
          // A low stop bit (framing error / break) must see the line go
          // high again before another frame can start.
          state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      ovr_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      data_out_q <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      ovr_q      <= ovr_d;
      wr_en_q    <= wr_en_d;
      data_out_q <= data_out_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed frames with a scoreboard queue of expected
// FIFO words; a monitor pops and compares on every wr_en.
module tb_uart_rx_deser;

  localparam int OVS_DIV = 4;
  localparam int BIT_CLK = OVS_DIV * 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        parity_odd = 1'b0;
  logic        full = 1'b0;
  logic        wr_en;
  logic [11:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  uart_rx_deser #(.OVS_DIV(OVS_DIV), .FIFO_WIDTH(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .parity_odd (parity_odd),
    .full       (full),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every write must match the oldest expected word.
  initial begin
    logic [11:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (rst_n && wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %03h want none", data_out);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL %s got %03h want %03h", n, data_out, e);
          end
        end
      end
    end
  end

  task automatic expect_word(input logic [11:0] w, input string n);
    exp_q.push_back(w);
    name_q.push_back(n);
  endtask

  task automatic check1(input string n, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0b want %0b", n, act, want);
    end
  endtask

  task automatic hold_bits(input int nbits);
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    hold_bits(1);
`else
    if (p) begin end
`endif
    rx = s;
    hold_bits(1);
    rx = 1'b1;
  endtask

  // Frame with the parity bit that matches parity_odd (no parity error).
  task automatic send_frame(input logic [7:0] d, input logic s);
    send_raw(d, (^d) ^ parity_odd, s);
  endtask

  task automatic drain(input string n);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4 * BIT_CLK) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending want 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_wr_en", wr_en, 1'b0);
    check1("rst_busy", busy, 1'b0);
    checks++;
    if (data_out !== 12'h000) begin
      errors++;
      $display("FAIL rst_data_out got %03h want 000", data_out);
    end
    rst_n = 1'b1;
    hold_bits(2);

    // Clean frame
    expect_word(12'h0A5, "frame_a5");
    send_frame(8'hA5, 1'b1);
    drain("frame_a5");
    repeat (8) @(negedge clk);
    check1("busy_after_a5", busy, 1'b0);
    // Output word holds after the strobe
    checks++;
    if (data_out !== 12'h0A5) begin
      errors++;
      $display("FAIL hold_a5 got %03h want 0a5", data_out);
    end

    // Start-bit glitch: low 3 ticks
    rx = 1'b0;
    repeat (3 * OVS_DIV) @(negedge clk);
    rx = 1'b1;
    hold_bits(2);
    check1("busy_after_glitch", busy, 1'b0);

    // Framing error
    expect_word(12'h23C, "frame_3c_ferr");
    send_frame(8'h3C, 1'b0);
    drain("frame_3c_ferr");
    hold_bits(1);

    // Break held for 20 bit times
    expect_word(12'h600, "break");
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hold_bits(4);
      check1("busy_in_break", busy, 1'b1);
    end
    drain("break");
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check1("busy_after_break", busy, 1'b0);
    hold_bits(1);

    // Overrun: dropped word, flagged on the next write, then cleared
    full = 1'b1;
    send_frame(8'h11, 1'b1);
    hold_bits(1);
    full = 1'b0;
    expect_word(12'h822, "overrun_22");
    send_frame(8'h22, 1'b1);
    drain("overrun_22");
    expect_word(12'h05A, "ovr_cleared_5a");
    send_frame(8'h5A, 1'b1);
    drain("ovr_cleared_5a");
    hold_bits(1);

    // Back-to-back frames, no idle gap
    expect_word(12'h0C3, "b2b_c3");
    expect_word(12'h07E, "b2b_7e");
    send_frame(8'hC3, 1'b1);
    send_frame(8'h7E, 1'b1);
    drain("b2b");
    hold_bits(1);

`ifdef UART_RX_PARITY_EN
    // Even parity, data 0x01, parity bit 0 -> parity error
    parity_odd = 1'b0;
    expect_word(12'h101, "parity_err_01");
    send_raw(8'h01, 1'b0, 1'b1);
    drain("parity_err_01");
    // Odd parity, correct parity bit
    parity_odd = 1'b1;
    expect_word(12'h096, "parity_odd_96");
    send_frame(8'h96, 1'b1);
    drain("parity_odd_96");
    parity_odd = 1'b0;
    hold_bits(1);
`endif

    // Reset mid-DATA aborts the frame
    rx = 1'b0;
    hold_bits(1);
    rx = 1'b1;
    hold_bits(1);
    rx = 1'b0;
    hold_bits(1);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_wr_en", wr_en, 1'b0);
    checks++;
    if (data_out !== 12'h000) begin
      errors++;
      $display("FAIL midrst_data_out got %03h want 000", data_out);
    end
    rst_n = 1'b1;
    hold_bits(12);
    check1("busy_after_midrst", busy, 1'b0);
    expect_word(12'h081, "after_rst_81");
    send_frame(8'h81, 1'b1);
    drain("after_rst_81");
    hold_bits(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 The block SHALL have parameter OVS_DIV, default 27, meaning clk cycles per 16x-oversample tick.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 12, meaning the width of the word written to the downstream RX FIFO.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 The block SHALL have port parity_odd, input, 1, parity sense (1 = odd, 0 = even); used only when the parity feature is compiled in.
REQ-007 The block SHALL have port full, input, 1, downstream FIFO full flag.
REQ-008 The block SHALL have port wr_en, output, 1, one-cycle write strobe to the FIFO.
REQ-009 The block SHALL have port data_out, output, FIFO_WIDTH, packed word: [7:0] data, [8] parity error, [9] framing error, [10] break, [11] overrun.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before use; the synchronized value is rx_s.
REQ-012 The tick generator SHALL pulse tick for one clk every OVS_DIV clks, free-running from reset.
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-014 In IDLE, rx_s = 0 SHALL move the FSM to START and clear the 4-bit tick counter.
REQ-015 In START, at the 8th tick, rx_s = 1 SHALL return the FSM to IDLE (glitch rejected, no write), and rx_s = 0 SHALL move it to DATA with the tick counter cleared.
REQ-016 In DATA, 8 bits SHALL be sampled LSB first, each at the 16th tick after the previous sample point.
REQ-017 After the 8th data bit, the FSM SHALL go to PARITY if the feature is compiled in, else to STOP.
REQ-018 In PARITY, one bit SHALL be sampled at the 16th tick; bit 8 SHALL be set if the XOR of data and the parity bit differs from parity_odd.
REQ-019 In STOP, rx_s SHALL be sampled at the 16th tick; rx_s = 0 SHALL set bit 9; bit 9 set together with data == 0x00 SHALL also set bit 10.
REQ-020 wr_en SHALL be high for exactly the one clk cycle following the stop-bit sample tick, when full = 0.
REQ-021 data_out SHALL be registered and stable in the cycle wr_en is high; it SHALL hold its value otherwise.
REQ-022 If full = 1 at the write point, the word SHALL be dropped, wr_en SHALL stay low, and a sticky overrun flag SHALL be set.
REQ-023 Bit 11 SHALL carry the sticky overrun flag on the next written word; the flag SHALL clear in the same cycle as that write.
REQ-024 After the stop sample, rx_s = 1 SHALL return the FSM to IDLE, and rx_s = 0 SHALL move it to WAIT_HIGH; WAIT_HIGH SHALL exit to IDLE on rx_s = 1.
REQ-025 A break held for multiple frame times SHALL produce exactly one word.
REQ-026 Back-to-back frames with no idle gap SHALL be received without loss.

Reset
REQ-027 On rst_n low, asynchronously: FSM to IDLE; wr_en = 0; data_out = 0; busy = 0; synchronizer flops = 1; shift register, tick counters and overrun flag = 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no write; after release, a frame SHALL be received only from the next falling edge seen in IDLE.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined SHALL include the PARITY state and the parity check.
REQ-030 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, data_out[8] SHALL be tied to 0, and parity_odd SHALL be ignored.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the data_out bit-field index constants and OVS = 16.
REQ-032 The tick generator SHALL be sub-module uart_baud_tick, parameterized by OVS_DIV.

Verification (OVS_DIV = 4, i.e. 64 clk per bit)
REQ-033 Frame 0xA5 with stop = 1 and full = 0 -> one wr_en pulse with data_out = 0x0A5, busy low afterwards.
REQ-034 rx low for 3 ticks then high -> no wr_en, FSM back in IDLE.
REQ-035 Frame 0x3C with stop = 0 -> data_out = 0x23C.
REQ-036 rx held low for 20 bit times -> exactly one word 0x600, busy held until rx returns high.
REQ-037 Frame 0x11 with full = 1, then frame 0x22 with full = 0 -> single write with data_out = 0x822.
REQ-038 With UART_RX_PARITY_EN, parity_odd = 0, data 0x01 and parity bit 0 -> data_out = 0x101; reset pulsed mid-DATA -> no write.
